// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: Wishbone B3 master that writes a seeded pattern in bursts,
// reads it back, and reports compare mismatches and bus errors.
module wb_traffic_gen #(
    parameter int              dw        = 32,
    parameter int              aw        = 32,
    parameter logic [aw-1:0]   BASE_ADR  = '0,
    parameter int              WORDS     = 64,
    parameter int              BURST_LEN = 4,
    parameter logic [31:0]     SEED      = 32'hA5A5_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    input  logic [dw-1:0]   wb_dat_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            bus_err_o,
    output logic [15:0]     err_cnt_o
);
    localparam int            BW     = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
    localparam logic [31:0]   K_LAST = 32'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     k_q, k_d;
    logic [BW-1:0]   bpos_q, bpos_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [2:0]      cti_q, cti_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic [dw/8-1:0] sel_q, sel_d;

    function automatic logic [dw-1:0] pat(input logic [31:0] k);
        return dw'(SEED ^ (k * 32'h0001_0001));
    endfunction

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        bpos_d    = bpos_q;
        err_cnt_d = err_cnt_q;
        bus_err_d = bus_err_q;
        done_d    = done_q;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d   = WR;
                k_d       = '0;
                bpos_d    = '0;
                err_cnt_d = '0;
                bus_err_d = 1'b0;
                done_d    = 1'b0;
            end
            WR, RD: if (wb_err_i) begin
                state_d   = DONE;
                bus_err_d = 1'b1;
                done_d    = 1'b1;
            end else if (wb_rty_i) begin
                state_d = (state_q == WR) ? WGAP : RGAP;
            end else if (wb_ack_i) begin
                if (state_q == RD && wb_dat_i != pat(k_q) && err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
                k_d    = (k_q == K_LAST) ? '0 : k_q + 32'd1;
                bpos_d = (bpos_q == B_LAST) ? '0 : bpos_q + 1'b1;
                // The last write beat leads straight into the read-phase gap
                if (k_q == K_LAST) begin
                    state_d = (state_q == WR) ? RGAP : DONE;
                    done_d  = (state_q == RD);
                end else if (bpos_q == B_LAST) begin
                    state_d = (state_q == WR) ? WGAP : RGAP;
                end
            end
            WGAP:    state_d = WR;
            RGAP:    state_d = RD;
            default: state_d = IDLE;
        endcase
        cyc_d  = (state_d == WR) || (state_d == RD);
        we_d   = (state_d == WR);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        cti_d  = !cyc_d ? 3'b000 : (BURST_LEN == 1) ? 3'b000 : (bpos_d == B_LAST) ? 3'b111 : 3'b010;
        adr_d  = cyc_d ? BASE_ADR + aw'(k_d * (dw / 8)) : '0;
        dat_d  = we_d ? pat(k_d) : '0;
        sel_d  = cyc_d ? '1 : '0;
        pass_d = done_d && (err_cnt_d == 16'd0) && !bus_err_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            k_q       <= '0;
            bpos_q    <= '0;
            err_cnt_q <= '0;
            bus_err_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            cti_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            bpos_q    <= bpos_d;
            err_cnt_q <= err_cnt_d;
            bus_err_q <= bus_err_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            cti_q     <= cti_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cti_o  = cti_q;
    assign wb_bte_o  = 2'b00;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign bus_err_o = bus_err_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_wb_traffic_gen.sv
// tb_wb_traffic_gen: directed bench with a delaying memory slave (burst master)
// and a zero-wait slave (classic-cycle master).
module tb_wb_traffic_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [31:0] dat;
        logic [1:0]  rsp;
    } beat_t;

    function automatic logic [31:0] pat(input int k);
        return 32'hA5A5_0000 ^ (32'(k) * 32'h0001_0001);
    endfunction

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] adr_a, dat_a, adr_b, dat_b;
    logic [31:0] rdat_a = '0, rdat_b = '0;
    logic [3:0]  sel_a, sel_b;
    logic [2:0]  cti_a, cti_b;
    logic [1:0]  bte_a, bte_b;
    logic        we_a, cyc_a, stb_a, we_b, cyc_b, stb_b;
    logic        ack_a = 1'b0, err_a = 1'b0, rty_a = 1'b0;
    logic        ack_b = 1'b0;
    logic        err_b = 1'b0, rty_b = 1'b0;
    logic        busy_a, done_a, pass_a, berr_a, busy_b, done_b, pass_b, berr_b;
    logic [15:0] ecnt_a, ecnt_b;

    wb_traffic_gen #(.WORDS(8), .BURST_LEN(4)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a),
        .wb_adr_o(adr_a), .wb_dat_o(dat_a), .wb_sel_o(sel_a), .wb_we_o(we_a),
        .wb_cti_o(cti_a), .wb_bte_o(bte_a), .wb_cyc_o(cyc_a), .wb_stb_o(stb_a),
        .wb_ack_i(ack_a), .wb_err_i(err_a), .wb_rty_i(rty_a), .wb_dat_i(rdat_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .bus_err_o(berr_a), .err_cnt_o(ecnt_a)
    );

    wb_traffic_gen #(.WORDS(3), .BURST_LEN(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b),
        .wb_adr_o(adr_b), .wb_dat_o(dat_b), .wb_sel_o(sel_b), .wb_we_o(we_b),
        .wb_cti_o(cti_b), .wb_bte_o(bte_b), .wb_cyc_o(cyc_b), .wb_stb_o(stb_b),
        .wb_ack_i(ack_b), .wb_err_i(err_b), .wb_rty_i(rty_b), .wb_dat_i(rdat_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .bus_err_o(berr_b), .err_cnt_o(ecnt_b)
    );

    // Slave A: 16-word memory, wait states cycling 0..4, optional err/rty/corruption
    logic [31:0] mem_a [16];
    int          dly_a = 0, wcnt_a = 0, nbeat_a = 0, selv_a = 0, gapv_a = 0;
    logic        err_en = 1'b0, rty_en = 1'b0, flip_en = 1'b0;
    logic [31:0] rty_adr = '0;
    beat_t       log_a[$];

    always @(posedge clk) begin
        ack_a <= 1'b0;
        err_a <= 1'b0;
        rty_a <= 1'b0;
        if (cyc_a && stb_a && !(ack_a || err_a || rty_a)) begin
            if (wcnt_a < dly_a) wcnt_a <= wcnt_a + 1;
            else begin
                wcnt_a  <= 0;
                nbeat_a <= nbeat_a + 1;
                dly_a   <= (nbeat_a * 3) % 5;
                if (sel_a != 4'hF || bte_a != 2'b00) selv_a <= selv_a + 1;
                if (err_en) begin
                    err_a <= 1'b1;
                    log_a.push_back(beat_t'{adr_a, cti_a, we_a, dat_a, 2'd2});
                end else if (rty_en && adr_a == rty_adr) begin
                    rty_a  <= 1'b1;
                    rty_en <= 1'b0;
                    log_a.push_back(beat_t'{adr_a, cti_a, we_a, dat_a, 2'd1});
                end else begin
                    ack_a <= 1'b1;
                    log_a.push_back(beat_t'{adr_a, cti_a, we_a, dat_a, 2'd0});
                    if (we_a) mem_a[adr_a[5:2]] <= dat_a;
                    else rdat_a <= mem_a[adr_a[5:2]];
                    if (flip_en && we_a && adr_a[5:2] == 4'd7) mem_a[3] <= mem_a[3] ^ 32'h1;
                end
            end
        end
    end

    // Gap monitor: after a burst end, rty or err, cyc is low for exactly one cycle
    logic c1_a = 1'b0, e1_a = 1'b0, e2_a = 1'b0;
    always @(negedge clk) begin
        if (!rst && e1_a && cyc_a) gapv_a <= gapv_a + 1;
        if (!rst && e2_a && !c1_a && !cyc_a && !done_a) gapv_a <= gapv_a + 1;
        c1_a <= cyc_a;
        e2_a <= e1_a;
        e1_a <= (ack_a && cti_a == 3'b111) || rty_a || err_a;
    end

    logic [31:0] mem_b [4];
    int          selv_b = 0, gapv_b = 0;
    beat_t       log_b[$];

    always @(posedge clk) begin
        ack_b <= 1'b0;
        if (cyc_b && stb_b && !ack_b) begin
            ack_b <= 1'b1;
            if (sel_b != 4'hF || bte_b != 2'b00) selv_b <= selv_b + 1;
            log_b.push_back(beat_t'{adr_b, cti_b, we_b, dat_b, 2'd0});
            if (we_b) mem_b[adr_b[3:2]] <= dat_b;
            else rdat_b <= mem_b[adr_b[3:2]];
        end
    end

    logic c1_b = 1'b0, e1_b = 1'b0, e2_b = 1'b0;
    always @(negedge clk) begin
        if (!rst && e1_b && cyc_b) gapv_b <= gapv_b + 1;
        if (!rst && e2_b && !c1_b && !cyc_b && !done_b) gapv_b <= gapv_b + 1;
        c1_b <= cyc_b;
        e2_b <= e1_b;
        e1_b <= ack_b;
    end

    task automatic pulse(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input string name);
        int n = 0;
        while (!(b ? done_b : done_a) && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(b ? done_b : done_a)) begin
            errors++;
            $display("FAIL %s: done_o timeout, got 0 required 1", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cyc_a, stb_a, busy_a, done_a, pass_a, berr_a, we_a} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl_a: got %b required 0000000", {cyc_a, stb_a, busy_a, done_a, pass_a, berr_a, we_a});
        end
        checks++;
        if (adr_a !== 32'h0 || cti_a !== 3'b000 || sel_a !== 4'h0 || ecnt_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus_a: adr=%h cti=%b sel=%h ecnt=%0d required all 0", adr_a, cti_a, sel_a, ecnt_a);
        end
        checks++;
        if ({cyc_b, busy_b, done_b, pass_b, berr_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl_b: got %b required 00000", {cyc_b, busy_b, done_b, pass_b, berr_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || cyc_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b cyc=%b required 0 0", busy_a, cyc_a);
        end
    endtask

    task automatic test_write_read;
        int g = gapv_a;
        log_a.delete();
        pulse(1'b0);
        checks++;
        if (busy_a !== 1'b1 || cyc_a !== 1'b1 || adr_a !== 32'h0 || cti_a !== 3'b010 || we_a !== 1'b1) begin
            errors++;
            $display("FAIL first_beat: busy=%b cyc=%b adr=%h cti=%b we=%b required 1 1 0 010 1", busy_a, cyc_a, adr_a, cti_a, we_a);
        end
        wait_done(1'b0, "write_read");
        checks++;
        if (log_a.size() != 16) begin
            errors++;
            $display("FAIL beat_count: got %0d required 16", log_a.size());
        end
        for (int i = 0; i < 16 && i < log_a.size(); i++) begin
            checks++;
            if (log_a[i].adr !== 32'((i % 8) * 4) || log_a[i].cti !== ((i % 4 == 3) ? 3'b111 : 3'b010) ||
                log_a[i].we !== (i < 8) || log_a[i].rsp !== 2'd0 || (i < 8 && log_a[i].dat !== pat(i))) begin
                errors++;
                $display("FAIL beat%0d: adr=%h cti=%b we=%b dat=%h required adr=%h cti=%b we=%b dat=%h", i,
                         log_a[i].adr, log_a[i].cti, log_a[i].we, log_a[i].dat, (i % 8) * 4,
                         (i % 4 == 3) ? 3'b111 : 3'b010, i < 8, pat(i % 8));
            end
        end
        checks++;
        if (mem_a[3] !== 32'hA5A6_0003 || mem_a[7] !== 32'hA5A2_0007) begin
            errors++;
            $display("FAIL mem_content: mem3=%h mem7=%h required a5a60003 a5a20007", mem_a[3], mem_a[7]);
        end
        checks++;
        if (pass_a !== 1'b1 || ecnt_a !== 16'd0 || busy_a !== 1'b0 || berr_a !== 1'b0) begin
            errors++;
            $display("FAIL wr_result: pass=%b ecnt=%0d busy=%b berr=%b required 1 0 0 0", pass_a, ecnt_a, busy_a, berr_a);
        end
        checks++;
        if (gapv_a !== g || selv_a !== 0) begin
            errors++;
            $display("FAIL wr_gaps_sel: gap_violations=%0d sel_violations=%0d required 0 0", gapv_a - g, selv_a);
        end
    endtask

    task automatic test_mismatch;
        flip_en = 1'b1;
        pulse(1'b0);
        wait_done(1'b0, "mismatch");
        flip_en = 1'b0;
        checks++;
        if (ecnt_a !== 16'd1 || pass_a !== 1'b0 || berr_a !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL mismatch: ecnt=%0d pass=%b berr=%b done=%b required 1 0 0 1", ecnt_a, pass_a, berr_a, done_a);
        end
    endtask

    task automatic test_bus_err;
        int g = gapv_a;
        int s = 0;
        err_en = 1'b1;
        log_a.delete();
        pulse(1'b0);
        wait_done(1'b0, "bus_err");
        checks++;
        if (berr_a !== 1'b1 || done_a !== 1'b1 || pass_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bus_err_flags: berr=%b done=%b pass=%b busy=%b required 1 1 0 0", berr_a, done_a, pass_a, busy_a);
        end
        repeat (8) begin
            @(negedge clk);
            if (stb_a) s++;
        end
        checks++;
        if (log_a.size() != 1 || s != 0 || gapv_a !== g) begin
            errors++;
            $display("FAIL bus_err_stop: beats=%0d later_stb=%0d gap_violations=%0d required 1 0 0", log_a.size(), s, gapv_a - g);
        end
        err_en = 1'b0;
    endtask

    task automatic test_retry;
        int g = gapv_a;
        rty_adr = 32'h8;
        rty_en  = 1'b1;
        log_a.delete();
        pulse(1'b0);
        wait_done(1'b0, "retry");
        checks++;
        if (log_a.size() != 17) begin
            errors++;
            $display("FAIL rty_count: got %0d required 17", log_a.size());
        end else begin
            checks++;
            if (log_a[2].adr !== 32'h8 || log_a[2].rsp !== 2'd1 || log_a[3].adr !== 32'h8 || log_a[3].cti !== 3'b010 ||
                log_a[3].rsp !== 2'd0 || log_a[4].adr !== 32'hC || log_a[4].cti !== 3'b111) begin
                errors++;
                $display("FAIL rty_reissue: b2=%h/%0d b3=%h/%b b4=%h/%b required 8/1 8/010 c/111",
                         log_a[2].adr, log_a[2].rsp, log_a[3].adr, log_a[3].cti, log_a[4].adr, log_a[4].cti);
            end
        end
        checks++;
        if (pass_a !== 1'b1 || gapv_a !== g) begin
            errors++;
            $display("FAIL rty_result: pass=%b gap_violations=%0d required 1 0", pass_a, gapv_a - g);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        log_a.delete();
        pulse(1'b0);
        while (log_a.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (cyc_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst: cyc=%b required 1", cyc_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cyc_a !== 1'b0 || stb_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cyc=%b stb=%b busy=%b required 0 0 0", cyc_a, stb_a, busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0);
        wait_done(1'b0, "after_reset");
        checks++;
        if (pass_a !== 1'b1 || ecnt_a !== 16'd0) begin
            errors++;
            $display("FAIL after_reset: pass=%b ecnt=%0d required 1 0", pass_a, ecnt_a);
        end
    endtask

    task automatic test_back_to_back;
        int g = gapv_b;
        int n = 0;
        log_b.delete();
        pulse(1'b1);
        while (log_b.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        pulse(1'b1);
        wait_done(1'b1, "classic");
        repeat (4) @(negedge clk);
        checks++;
        if (log_b.size() != 6 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL classic_count: beats=%0d done=%b required 6 1", log_b.size(), done_b);
        end
        for (int i = 0; i < 6 && i < log_b.size(); i++) begin
            checks++;
            if (log_b[i].adr !== 32'((i % 3) * 4) || log_b[i].cti !== 3'b000 || log_b[i].we !== (i < 3)) begin
                errors++;
                $display("FAIL classic_beat%0d: adr=%h cti=%b we=%b required %h 000 %b", i,
                         log_b[i].adr, log_b[i].cti, log_b[i].we, (i % 3) * 4, i < 3);
            end
        end
        checks++;
        if (pass_b !== 1'b1 || gapv_b !== g || selv_b !== 0) begin
            errors++;
            $display("FAIL classic_result: pass=%b gap_violations=%0d sel_violations=%0d required 1 0 0", pass_b, gapv_b - g, selv_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mismatch();
        test_bus_err();
        test_retry();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
